// File: rtl/spi_flash_reader.sv
// Wishbone-style read slave that turns each x_cyc request into one SPI flash READ (0x03):
// opcode plus 24-bit address out, 32 data bits in, returned little-endian with a one-cycle ack.
module spi_flash_reader #(
   parameter int unsigned CLK_DIV = 1,
   parameter int unsigned CS_GAP  = 2
) (
   input  logic        wb_clk,
   input  logic        wb_rst,
   input  logic        x_cyc,
   input  logic [31:0] x_adr,
   output logic        x_ack,
   output logic [31:0] x_rdt,
   output logic        busy,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StData,
      StDone,
      StGap
   } state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [GapW-1:0]   gap_q, gap_d;
   logic [4:0]        bit_q, bit_d;
   logic [31:0]       tx_q, tx_d;
   logic [31:0]       rx_q, rx_d;
   logic              settle_q, settle_d;
   logic              cs_n_q, cs_n_d;
   logic              sck_q, sck_d;
   logic              mosi_q, mosi_d;
   logic              ack_q, ack_d;
   logic [31:0]       rdt_q, rdt_d;
   logic              busy_q, busy_d;

   logic              sck_tick;
   logic              sck_rise;
   logic              sck_fall;

   assign sck_tick = (div_q == DivLast);
   assign sck_rise = sck_tick && !sck_q;
   assign sck_fall = sck_tick && sck_q;

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      gap_d    = gap_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      settle_d = settle_q;
      cs_n_d   = cs_n_q;
      sck_d    = sck_q;
      mosi_d   = mosi_q;
      busy_d   = busy_q;
      ack_d    = 1'b0;
      rdt_d    = '0;

      unique case (state_q)
         StIdle: begin
            if (x_cyc) begin
               tx_d    = {8'h03, x_adr[23:0]};
               mosi_d  = 1'b0;  // MSB of the 0x03 opcode
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               sck_d   = 1'b0;
               div_d   = '0;
               bit_d   = '0;
               state_d = StAddr;
            end
         end

         StAddr: begin
            if (sck_tick) begin
               div_d = '0;
               sck_d = ~sck_q;
            end else begin
               div_d = div_q + 1'b1;
            end
            if (sck_fall) begin
               tx_d  = {tx_q[30:0], 1'b0};
               bit_d = bit_q + 5'd1;
               if (bit_q == 5'd31) begin
                  mosi_d  = 1'b0;
                  state_d = StData;
               end else begin
                  mosi_d = tx_q[30];
               end
            end
         end

         StData: begin
            if (sck_tick) begin
               div_d = '0;
               sck_d = ~sck_q;
            end else begin
               div_d = div_q + 1'b1;
            end
            if (sck_rise) begin
               rx_d = {rx_q[30:0], spi_miso};
            end
            if (sck_fall) begin
               bit_d = bit_q + 5'd1;
               if (bit_q == 5'd31) begin
                  settle_d = 1'b0;
                  state_d  = StDone;
               end
            end
         end

         StDone: begin
            // One settle cycle after the last falling edge, then ack with the byte-swapped word.
            if (!settle_q) begin
               settle_d = 1'b1;
            end else begin
               ack_d   = 1'b1;
               rdt_d   = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
               cs_n_d  = 1'b1;
               gap_d   = '0;
               state_d = StGap;
            end
         end

         StGap: begin
            if (gap_q == GapLast) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state_q  <= StIdle;
         div_q    <= '0;
         gap_q    <= '0;
         bit_q    <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         settle_q <= 1'b0;
         cs_n_q   <= 1'b1;
         sck_q    <= 1'b0;
         mosi_q   <= 1'b0;
         ack_q    <= 1'b0;
         rdt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         gap_q    <= gap_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         settle_q <= settle_d;
         cs_n_q   <= cs_n_d;
         sck_q    <= sck_d;
         mosi_q   <= mosi_d;
         ack_q    <= ack_d;
         rdt_q    <= rdt_d;
         busy_q   <= busy_d;
      end
   end

   assign x_ack    = ack_q;
   assign x_rdt    = rdt_q;
   assign busy     = busy_q;
   assign spi_cs_n = cs_n_q;
   assign spi_sck  = sck_q;
   assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: two instances (CLK_DIV=1 and CLK_DIV=3), each with a byte[a]=a[7:0]
// SPI flash model and a protocol monitor; directed and random reads checked against a word model.
module tb_spi_flash_reader;

   localparam int unsigned CsGap = 2;

   logic        wb_clk = 1'b0;
   logic        wb_rst;
   logic [1:0]  x_cyc;
   logic [31:0] x_adr [2];
   wire  [1:0]  x_ack;
   wire  [31:0] x_rdt [2];
   wire  [1:0]  busy;
   wire  [1:0]  spi_cs_n;
   wire  [1:0]  spi_sck;
   wire  [1:0]  spi_mosi;

   wire  [31:0] m_rises    [2];
   wire  [31:0] m_stream   [2];
   wire  [31:0] m_falls    [2];
   wire  [31:0] m_acks     [2];
   wire  [31:0] m_mosi_err [2];
   wire  [31:0] m_rdt_err  [2];
   wire  [31:0] m_cs_err   [2];

   int vectors = 0;
   int miscompares = 0;

   always #5 wb_clk = ~wb_clk;

   for (genvar g = 0; g < 2; g++) begin : g_inst
      logic        miso_r = 1'b0;
      logic        prev_cs = 1'b1;
      logic        pmosi = 1'b0;
      logic [31:0] sh = '0;
      logic [31:0] last_sh = '0;
      logic [7:0]  fb;
      int          rcnt = 0;
      int          bi;
      int          last_rises = 0;
      int          falls = 0;
      int          acks = 0;
      int          mosi_err = 0;
      int          rdt_err = 0;
      int          cs_err = 0;

      spi_flash_reader #(
         .CLK_DIV (g == 0 ? 1 : 3),
         .CS_GAP  (CsGap)
      ) u_dut (
         .wb_clk   (wb_clk),
         .wb_rst   (wb_rst),
         .x_cyc    (x_cyc[g]),
         .x_adr    (x_adr[g]),
         .x_ack    (x_ack[g]),
         .x_rdt    (x_rdt[g]),
         .busy     (busy[g]),
         .spi_cs_n (spi_cs_n[g]),
         .spi_sck  (spi_sck[g]),
         .spi_mosi (spi_mosi[g]),
         .spi_miso (miso_r)
      );

      // Flash: capture command/address on rising SCK, shift data out on falling SCK.
      always @(posedge spi_sck[g] or negedge spi_sck[g] or posedge spi_cs_n[g]
               or negedge spi_cs_n[g]) begin
         if (spi_cs_n[g] !== 1'b0) begin
            if (!prev_cs) begin
               last_rises = rcnt;
               last_sh    = sh;
            end
            prev_cs = 1'b1;
         end else if (prev_cs) begin
            rcnt    = 0;
            falls   = falls + 1;
            prev_cs = 1'b0;
         end else if (spi_sck[g] === 1'b1) begin
            if (rcnt < 32) sh = {sh[30:0], spi_mosi[g]};
            rcnt = rcnt + 1;
         end else if (rcnt >= 32 && rcnt < 64) begin
            bi     = rcnt - 32;
            fb     = 8'(sh[23:0] + 24'(bi / 8));
            miso_r = fb[7 - (bi % 8)];
         end
      end

      always @(negedge wb_clk) begin
         if (spi_cs_n[g] === 1'b0 && spi_sck[g] === 1'b1 && spi_mosi[g] !== pmosi)
            mosi_err = mosi_err + 1;
         if (x_ack[g] !== 1'b1 && x_rdt[g] !== 32'd0) rdt_err = rdt_err + 1;
         if (spi_cs_n[g] === 1'b0 && busy[g] !== 1'b1) cs_err = cs_err + 1;
         if (x_ack[g] === 1'b1) acks = acks + 1;
         pmosi = spi_mosi[g];
      end

      assign m_rises[g]    = 32'(last_rises);
      assign m_stream[g]   = last_sh;
      assign m_falls[g]    = 32'(falls);
      assign m_acks[g]     = 32'(acks);
      assign m_mosi_err[g] = 32'(mosi_err);
      assign m_rdt_err[g]  = 32'(rdt_err);
      assign m_cs_err[g]   = 32'(cs_err);
   end

   function automatic logic [31:0] model_word(input logic [31:0] adr);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(adr[23:0] + 24'(i));
      return w;
   endfunction

   function automatic int latency_of(input int k);
      return 2 + 128 * ((k == 0) ? 1 : 3);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp)
      else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic req(input int k, input logic [31:0] adr);
      x_adr[k] = adr;
      x_cyc[k] = 1'b1;
   endtask

   task automatic wait_cs_low(input int k, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (spi_cs_n[k] !== 1'b0 && n < 1000);
   endtask

   // Counts edges from the start edge (n0 already elapsed) until x_ack is seen, then checks.
   task automatic finish_xfer(input int k, input logic [31:0] adr, input string tag, input int n0);
      int          n;
      logic [31:0] d;
      n = n0;
      d = 'x;
      while (n < 2000) begin
         step();
         n++;
         if (x_ack[k] === 1'b1) begin
            d = x_rdt[k];
            break;
         end
      end
      chk({tag, "/latency"}, 32'(n), 32'(latency_of(k)));
      chk({tag, "/rdt"}, d, model_word(adr));
      chk({tag, "/mosi"}, m_stream[k], {8'h03, adr[23:0]});
      chk({tag, "/sck_rises"}, m_rises[k], 32'd64);
   endtask

   task automatic full_read(input int k, input logic [31:0] adr, input string tag);
      int          n;
      logic [31:0] acks0;
      acks0 = m_acks[k];
      req(k, adr);
      wait_cs_low(k, n);
      chk({tag, "/start"}, 32'(n), 32'd1);
      x_adr[k] = ~adr;
      finish_xfer(k, adr, tag, 0);
      x_cyc[k] = 1'b0;
      step();
      chk({tag, "/ack_pulse"}, {31'd0, x_ack[k]}, 32'd0);
      chk({tag, "/rdt_zero"}, x_rdt[k], 32'd0);
      chk({tag, "/busy_gap"}, {31'd0, busy[k]}, 32'd1);
      step();
      chk({tag, "/busy_end"}, {31'd0, busy[k]}, 32'd0);
      chk({tag, "/ack_count"}, m_acks[k] - acks0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] adr;
      logic [31:0] acks0;
      logic [31:0] falls0;

      wb_rst   = 1'b1;
      x_cyc    = '0;
      x_adr[0] = '0;
      x_adr[1] = '0;
      repeat (3) step();
      wb_rst = 1'b0;
      step();

      for (int k = 0; k < 2; k++) begin
         chk("reset/cs_n", {31'd0, spi_cs_n[k]}, 32'd1);
         chk("reset/sck", {31'd0, spi_sck[k]}, 32'd0);
         chk("reset/mosi", {31'd0, spi_mosi[k]}, 32'd0);
         chk("reset/ack", {31'd0, x_ack[k]}, 32'd0);
         chk("reset/rdt", x_rdt[k], 32'd0);
         chk("reset/busy", {31'd0, busy[k]}, 32'd0);
      end

      full_read(0, 32'h0010_0000, "single_div1");
      full_read(1, 32'h0012_3456, "single_div3");
      full_read(1, 32'hFF12_3456, "hi_ignored_div3");

      for (int i = 0; i < 6; i++) begin
         full_read(i % 2, $urandom, "random");
      end

      // Back-to-back: x_cyc stays high with the next address right after the first ack.
      falls0 = m_falls[0];
      req(0, 32'haaaa_aaa1);
      wait_cs_low(0, n);
      finish_xfer(0, 32'haaaa_aaa1, "b2b_first", 0);
      req(0, 32'hbbbb_bbb1);
      wait_cs_low(0, n);
      chk("b2b/gap_edges", 32'(n), 32'(CsGap + 1));
      finish_xfer(0, 32'hbbbb_bbb1, "b2b_second", 0);
      x_cyc[0] = 1'b0;
      repeat (3) step();
      chk("b2b/cs_windows", m_falls[0] - falls0, 32'd2);

      // Reset mid-ADDR: outputs fall back asynchronously, no ack follows.
      adr = $urandom;
      req(0, adr);
      wait_cs_low(0, n);
      repeat (19) step();
      acks0    = m_acks[0];
      x_cyc[0] = 1'b0;
      wb_rst   = 1'b1;
      #1;
      chk("rst_mid/cs_n", {31'd0, spi_cs_n[0]}, 32'd1);
      chk("rst_mid/sck", {31'd0, spi_sck[0]}, 32'd0);
      step();
      wb_rst = 1'b0;
      repeat (200) step();
      chk("rst_mid/no_ack", m_acks[0] - acks0, 32'd0);
      chk("rst_mid/busy", {31'd0, busy[0]}, 32'd0);
      full_read(0, $urandom, "after_rst");

      // x_cyc dropped mid-transaction: it still completes once, nothing restarts.
      acks0  = m_acks[0];
      falls0 = m_falls[0];
      adr    = $urandom;
      req(0, adr);
      wait_cs_low(0, n);
      repeat (39) step();
      x_cyc[0] = 1'b0;
      finish_xfer(0, adr, "drop_cyc", 39);
      repeat (300) step();
      chk("drop_cyc/acks", m_acks[0] - acks0, 32'd1);
      chk("drop_cyc/windows", m_falls[0] - falls0, 32'd1);

      for (int k = 0; k < 2; k++) begin
         chk("proto/mosi_stable", m_mosi_err[k], 32'd0);
         chk("proto/rdt_zero", m_rdt_err[k], 32'd0);
         chk("proto/cs_busy", m_cs_err[k], 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
